// File: rtl/synaptic_sram_arbiter.sv
// Shares one single-port synaptic SRAM between inference reads and learning read-modify-write updates.
// Define SYN_ARB_SAT_EN for saturating 8-bit lane sums; by default lane sums wrap modulo 256.
module synaptic_sram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inf_req,
  input  logic [ADDR_WIDTH-1:0] inf_addr,
  output logic                  inf_gnt,
  output logic                  inf_rvalid,
  output logic [DATA_WIDTH-1:0] inf_rdata,
  input  logic                  upd_req,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic [DATA_WIDTH-1:0] upd_delta,
  output logic                  upd_gnt,
  output logic                  upd_done,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, UPD_CALC, UPD_WR} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           starve;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_delta, result, sum;

  always_comb begin
    state_nxt = state;
    inf_gnt   = 1'b0;
    upd_gnt   = 1'b0;
    upd_done  = 1'b0;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_a    = inf_addr;
    sram_d    = result;
    if (!rst) begin
      case (state)
        IDLE: begin
          // a starved update pre-empts inference only once the limit is reached
          inf_gnt = inf_req && !(upd_req && starve == LIMIT);
          upd_gnt = upd_req && !inf_gnt;
          sram_cs = inf_gnt || upd_gnt;
          sram_a  = inf_gnt ? inf_addr : upd_addr;
          if (upd_gnt) state_nxt = UPD_CALC;
        end
        UPD_CALC: state_nxt = UPD_WR;
        UPD_WR: begin
          sram_cs   = 1'b1;
          sram_we   = 1'b1;
          sram_a    = cap_addr;
          upd_done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SYN_ARB_SAT_EN
    logic [8:0] s;
    assign s = {sram_q[8*i+7], sram_q[8*i +: 8]} + {cap_delta[8*i+7], cap_delta[8*i +: 8]};
    // sign disagreement between bits 8 and 7 marks an overflow; clamp toward the true sign
    assign sum[8*i +: 8] = (s[8] != s[7]) ? (s[8] ? 8'h80 : 8'h7F) : s[7:0];
`else
    assign sum[8*i +: 8] = sram_q[8*i +: 8] + cap_delta[8*i +: 8];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve     <= '0;
      inf_rvalid <= 1'b0;
      cap_addr   <= '0;
      cap_delta  <= '0;
      result     <= '0;
    end else begin
      state      <= state_nxt;
      inf_rvalid <= inf_gnt;
      if (upd_gnt) begin
        cap_addr  <= upd_addr;
        cap_delta <= upd_delta;
      end
      if (state == UPD_CALC) result <= sum;
      if (!upd_req || upd_gnt) starve <= '0;
      else if (inf_gnt && starve != LIMIT) starve <= starve + 1'b1;
    end
  end

  // SRAM output is live in the cycle after the grant; gate so idle read data stays zero
  assign inf_rdata = inf_rvalid ? sram_q : '0;

endmodule

// File: tb/tb_synaptic_sram_arbiter.sv
// Randomized and directed bench for synaptic_sram_arbiter against a cycle-level behavioural model.
module tb_synaptic_sram_arbiter;
  localparam int AW = 8, DW = 32, LIM = 4;
`ifdef SYN_ARB_SAT_EN
  localparam logic [DW-1:0] EXP29 = 32'h7F80_0000;
`else
  localparam logic [DW-1:0] EXP29 = 32'h8976_0000;
`endif

  logic clk = 1'b0, rst;
  logic inf_req, upd_req, inf_gnt, inf_rvalid, upd_gnt, upd_done, sram_cs, sram_we;
  logic [AW-1:0] inf_addr, upd_addr, sram_a;
  logic [DW-1:0] upd_delta, inf_rdata, sram_d, sram_q;

  logic [DW-1:0] mem  [2**AW];
  logic [DW-1:0] gold [2**AW];
  int n_chk = 0, n_fail = 0;
  int busy, starve, cyc_no, n_ig, n_ug, n_rv, n_we, n_done, ug_cyc, we_cyc, last_g;
  bit exp_rv, last_infw, last_updw;
  logic [DW-1:0] exp_rdata, pend_word, last_wdata, last_rdata;
  logic [AW-1:0] pend_addr;
  int pat [12] = '{1, 1, 1, 1, 2, 0, 0, 1, 1, 1, 1, 2};

  synaptic_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .inf_req(inf_req), .inf_addr(inf_addr), .inf_gnt(inf_gnt),
    .inf_rvalid(inf_rvalid), .inf_rdata(inf_rdata),
    .upd_req(upd_req), .upd_addr(upd_addr), .upd_delta(upd_delta),
    .upd_gnt(upd_gnt), .upd_done(upd_done),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // synchronous single-port SRAM
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_a] = sram_d;
      else sram_q <= mem[sram_a];
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_add(logic [DW-1:0] w, logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW/8; i++) begin
      int s;
      s = int'($signed(w[8*i +: 8])) + int'($signed(d[8*i +: 8]));
`ifdef SYN_ARB_SAT_EN
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`endif
      r[8*i +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic put(int a, logic [DW-1:0] v);
    mem[AW'(a)]  = v;
    gold[AW'(a)] = v;
  endtask

  task automatic clr();
    n_ig = 0; n_ug = 0; n_rv = 0; n_we = 0; n_done = 0; ug_cyc = -1; we_cyc = -1;
  endtask

  // one clock: check outputs mid-cycle against the model, then advance the model at the edge
  task automatic cyc();
    bit infw, updw, ecs, ewe;
    @(negedge clk);
    infw = 1'b0; updw = 1'b0;
    if (!rst && busy == 0) begin
      infw = inf_req && !(upd_req && starve == LIM);
      updw = upd_req && !infw;
    end
    ewe = !rst && busy == 1;
    ecs = infw || updw || ewe;
    chk("inf_gnt", inf_gnt, infw);
    chk("upd_gnt", upd_gnt, updw);
    chk("sram_cs", sram_cs, ecs);
    chk("sram_we", sram_we, ewe);
    chk("upd_done", upd_done, ewe);
    chk("inf_rvalid", inf_rvalid, exp_rv);
    if (exp_rv) chk("inf_rdata", inf_rdata, exp_rdata);
    if (infw) chk("sram_a_inf", sram_a, inf_addr);
    else if (updw) chk("sram_a_upd", sram_a, upd_addr);
    else if (ewe) begin
      chk("sram_a_wr", sram_a, pend_addr);
      chk("sram_d_wr", sram_d, pend_word);
    end
    if (inf_gnt) n_ig++;
    if (upd_gnt) begin n_ug++; ug_cyc = cyc_no; end
    if (inf_rvalid) begin n_rv++; last_rdata = inf_rdata; end
    if (sram_we) begin n_we++; we_cyc = cyc_no; last_wdata = sram_d; end
    if (upd_done) n_done++;
    last_g = inf_gnt ? 1 : (upd_gnt ? 2 : 0);
    @(posedge clk);
    if (rst) begin
      busy = 0; starve = 0; exp_rv = 1'b0;
    end else begin
      exp_rv = infw;
      if (infw) exp_rdata = gold[inf_addr];
      if (busy == 1) begin gold[pend_addr] = pend_word; busy = 0; end
      else if (busy == 2) busy = 1;
      else if (updw) begin
        pend_addr = upd_addr;
        pend_word = lane_add(gold[upd_addr], upd_delta);
        busy = 2;
      end
      if (!upd_req || updw) starve = 0;
      else if (infw && starve < LIM) starve++;
    end
    last_infw = infw; last_updw = updw; cyc_no++;
    #1;
  endtask

  initial begin
    rst = 1'b1; inf_req = 1'b0; upd_req = 1'b0; inf_addr = '0; upd_addr = '0; upd_delta = '0;
    busy = 0; starve = 0; exp_rv = 1'b0; cyc_no = 0; last_infw = 1'b0; last_updw = 1'b0;
    exp_rdata = '0; pend_word = '0; pend_addr = '0; last_wdata = '0; last_rdata = '0;
    for (int i = 0; i < 2**AW; i++) put(i, $urandom);
    clr();
    repeat (2) @(posedge clk);
    #1;

    // reset must mask both requesters
    inf_req = 1'b1; upd_req = 1'b1;
    cyc(); cyc();
    chk("rst_grants", n_ig + n_ug, 0);
    chk("rst_rvalid", inf_rvalid, 1'b0);
    chk("rst_rdata", inf_rdata, '0);
    inf_req = 1'b0; upd_req = 1'b0; rst = 1'b0;
    cyc();

    // back-to-back reads
    put(8'h10, 32'h1122_3344); clr();
    inf_req = 1'b1; inf_addr = 8'h10;
    repeat (3) cyc();
    inf_req = 1'b0; cyc();
    chk("r27_gnts", n_ig, 3);
    chk("r27_rvalid", n_rv, 3);
    chk("r27_data", last_rdata, 32'h1122_3344);

    // wrapping/signed lane update
    put(8'h05, 32'h0102_0304); clr();
    upd_req = 1'b1; upd_addr = 8'h05; upd_delta = 32'h01FF_0102;
    cyc(); upd_req = 1'b0; repeat (3) cyc();
    chk("r28_wdata", last_wdata, 32'h0201_0406);
    chk("r28_done", n_done, 1);
    chk("r28_lat", we_cyc - ug_cyc, 2);

    // lane overflow behaviour
    put(8'h06, 32'h7F80_0000); clr();
    upd_req = 1'b1; upd_addr = 8'h06; upd_delta = 32'h0AF6_0000;
    cyc(); upd_req = 1'b0; repeat (3) cyc();
    chk("r29_wdata", last_wdata, EXP29);

    // starvation limit with both requesters held high
    clr();
    inf_req = 1'b1; inf_addr = 8'h20; upd_req = 1'b1; upd_addr = 8'h21; upd_delta = 32'h0101_0101;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("r30_seq", last_g, pat[i]);
    end
    inf_req = 1'b0; upd_req = 1'b0;
    repeat (3) cyc();

    // reset mid-update aborts the write
    clr();
    upd_req = 1'b1; upd_addr = 8'h07; upd_delta = 32'h0505_0505;
    cyc(); upd_req = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0; inf_req = 1'b1; inf_addr = 8'h07;
    cyc(); inf_req = 1'b0;
    repeat (3) cyc();
    chk("r31_we", n_we, 0);
    chk("r31_done", n_done, 0);
    chk("r31_idle_gnt", n_ig, 1);

    // random traffic over a small address window so reads and updates collide
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!inf_req || last_infw) begin
        inf_req  = ($urandom_range(0, 3) != 0);
        inf_addr = AW'($urandom_range(0, 15));
      end
      if (!upd_req || last_updw) begin
        upd_req   = ($urandom_range(0, 2) == 0);
        upd_addr  = AW'($urandom_range(0, 15));
        upd_delta = $urandom;
      end
      cyc();
    end
    rst = 1'b0; inf_req = 1'b0; upd_req = 1'b0;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/synaptic_sram_arbiter.md
SYNAPTIC_SRAM_ARBITER -- requirements
Module: synaptic_sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the synaptic SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the SRAM word width; it SHALL be a multiple of 8 (packed 8-bit signed weight lanes).
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive inference grants while UPD_REQ is pending.
REQ-004 CLK, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 RST, input, 1: reset, synchronous and active-high.
REQ-006 INF_REQ, input, 1; INF_ADDR, input, ADDR_WIDTH: inference read request and address.
REQ-007 INF_GNT, output, 1; INF_RVALID, output, 1; INF_RDATA, output, DATA_WIDTH: read grant, read-data valid, read data.
REQ-008 UPD_REQ, input, 1; UPD_ADDR, input, ADDR_WIDTH; UPD_DELTA, input, DATA_WIDTH: learning read-modify-write request, address, packed signed 8-bit deltas.
REQ-009 UPD_GNT, output, 1; UPD_DONE, output, 1: update accepted, update write issued.
REQ-010 SRAM_CS, SRAM_WE, outputs, 1; SRAM_A, output, ADDR_WIDTH; SRAM_D, output, DATA_WIDTH; SRAM_Q, input, DATA_WIDTH: port to the single-port synchronous synaptic SRAM (read data valid one cycle after CS).

Function
REQ-011 FSM states SHALL be IDLE, UPD_CALC, UPD_WR; arbitration SHALL occur only in IDLE.
REQ-012 In IDLE, inference SHALL win when INF_REQ=1, unless UPD_REQ=1 and the starve counter equals STARVE_LIMIT, in which case the update SHALL win.
REQ-013 In IDLE, with UPD_REQ=1 and INF_REQ=0, the update SHALL win.
REQ-014 Inference grant (combinational, same cycle): INF_GNT=1, SRAM_CS=1, SRAM_WE=0, SRAM_A=INF_ADDR; FSM stays IDLE, so back-to-back reads at one per cycle SHALL be supported.
REQ-015 INF_RVALID SHALL be 1 in the cycle after each inference grant, with INF_RDATA=SRAM_Q.
REQ-016 Update grant in cycle T: UPD_GNT=1, SRAM_CS=1, SRAM_WE=0, SRAM_A=UPD_ADDR; UPD_ADDR and UPD_DELTA SHALL be captured; next state UPD_CALC.
REQ-017 UPD_CALC (T+1): per lane i (bits 8i+7:8i), result = SRAM_Q lane + captured delta lane, signed; result registered; SRAM_CS=0; next state UPD_WR.
REQ-018 UPD_WR (T+2): SRAM_CS=1, SRAM_WE=1, SRAM_A=captured address, SRAM_D=registered result, UPD_DONE=1; next state IDLE.
REQ-019 INF_GNT and UPD_GNT SHALL be 0 in UPD_CALC and UPD_WR; requesters SHALL hold REQ and address stable until granted.
REQ-020 Starve counter SHALL increment on each inference grant while UPD_REQ=1, saturate at STARVE_LIMIT, and clear on update grant or whenever UPD_REQ=0.
REQ-021 Without grant, SRAM_CS SHALL be 0 and SRAM_WE SHALL be 0.

Reset
REQ-022 On RST=1 at a clock edge: state IDLE, starve counter 0, INF_RVALID 0, UPD_DONE 0, captured address/delta/result 0, INF_RDATA 0.
REQ-023 RST asserted in UPD_CALC or UPD_WR SHALL abort the update; no SRAM write SHALL be issued after that edge.
REQ-024 While RST=1, all grants, SRAM_CS and SRAM_WE SHALL be 0.

Configuration
REQ-025 Macro SYN_ARB_SAT_EN defined: each lane sum SHALL saturate to [-128, 127].
REQ-026 SYN_ARB_SAT_EN undefined: each lane sum SHALL wrap modulo 256 (two's complement).

Verification
REQ-027 INF_REQ=1 addr 0x10 for 3 cycles, word 0x11223344 at 0x10 -> INF_GNT 3 cycles, INF_RVALID 3 cycles one cycle later, data 0x11223344 each.
REQ-028 UPD_REQ addr 0x05, word 0x01020304, delta 0x01FF0102 -> grant T, SRAM write at T+2 of 0x02010406, UPD_DONE=1 at T+2 only.
REQ-029 With SYN_ARB_SAT_EN: word 0x7F80_0000 lanes, delta 0x0AF6_0000 -> written 0x7F80_0000; without: 0x8976_0000.
REQ-030 INF_REQ and UPD_REQ held high continuously, STARVE_LIMIT=4 -> 4 inference grants, then update grant, 2 blocked cycles, then inference resumes.
REQ-031 RST pulsed in UPD_CALC -> no write cycle (SRAM_WE stays 0), UPD_DONE stays 0, FSM in IDLE next cycle.
REQ-032 Simultaneous INF_REQ and UPD_REQ with counter 0 -> INF_GNT=1, UPD_GNT=0, counter becomes 1.
